// File: rtl/reg_writeback_queue_pkg.sv
// Shared register-file definitions for the writeback queue slice.
package reg_writeback_queue_pkg;

    localparam int unsigned RF_ADDR_WIDTH = 5;
    localparam int unsigned RF_DATA_WIDTH = 32;
    localparam int unsigned RF_NUM_REGS   = 32;

    typedef struct packed {
        logic [RF_ADDR_WIDTH-1:0] addr;
        logic [RF_DATA_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/reg_writeback_queue_if.sv
// Producer-side valid/ready push channel into the writeback queue.
interface reg_writeback_queue_if #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
);

    logic                  inValid;
    logic                  inReady;
    logic [ADDR_WIDTH-1:0] inAddress;
    logic [DATA_WIDTH-1:0] inData;

    modport master (output inValid, inAddress, inData, input inReady);
    modport slave  (input inValid, inAddress, inData, output inReady);

endinterface

// File: rtl/reg_writeback_queue_wb_fwd_match.sv
// Youngest-match forwarding select for one read port.
// Entries arrive ordered oldest (index 0) to youngest (index DEPTH-1).
module reg_writeback_queue_wb_fwd_match #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] readAddress_i,
    input  logic [DEPTH-1:0]      entValid_i,
    input  logic [ADDR_WIDTH-1:0] entAddr_i [DEPTH],
    input  logic [DATA_WIDTH-1:0] entData_i [DEPTH],
    output logic                  fwdHit_o,
    output logic [DATA_WIDTH-1:0] fwdData_o
);

    // Scan oldest to youngest so the last (youngest) match overrides older ones.
    always_comb begin
        fwdHit_o  = 1'b0;
        fwdData_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entValid_i[i] && (entAddr_i[i] == readAddress_i)) begin
                fwdHit_o  = 1'b1;
                fwdData_o = entData_i[i];
            end
        end
    end

endmodule

// File: rtl/reg_writeback_queue.sv
// In-order writeback FIFO in front of regFile's write port, with
// youngest-match forwarding onto both read ports.
module reg_writeback_queue
    import reg_writeback_queue_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     resetN,
    reg_writeback_queue_if.slave     inPort,
    input  logic                     drainEn,
    output logic [ADDR_WIDTH-1:0]    writeAddress,
    output logic [DATA_WIDTH-1:0]    writeData,
    output logic                     writeEnable,
    input  logic [ADDR_WIDTH-1:0]    readAddress0,
    input  logic [ADDR_WIDTH-1:0]    readAddress1,
    output logic                     fwdHit0,
    output logic [DATA_WIDTH-1:0]    fwdData0,
    output logic                     fwdHit1,
    output logic [DATA_WIDTH-1:0]    fwdData1,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [ADDR_WIDTH-1:0] addr_q  [DEPTH];
    logic [DATA_WIDTH-1:0] data_q  [DEPTH];
    logic [DEPTH-1:0]      valid_q;
    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;

    logic empty, full, doPush, doPop;

    assign empty  = (count_q == '0);
    assign full   = (count_q == FULL_COUNT);
    assign doPush = inPort.inValid && !full;
    assign doPop  = !empty && drainEn;

    assign inPort.inReady = !full;
    assign writeEnable    = doPop;
    assign writeAddress   = empty ? '0 : addr_q[head_q];
    assign writeData      = empty ? '0 : data_q[head_q];
    assign count          = count_q;

    // Pointer and occupancy next-state; pointers wrap naturally at power-of-two DEPTH.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (doPush) tail_d = tail_q + PW'(1);
        if (doPop)  head_d = head_q + PW'(1);
        if (doPush && !doPop)      count_d = count_q + CW'(1);
        else if (!doPush && doPop) count_d = count_q - CW'(1);
    end

    // Entry storage and pointers; reset discards every pending entry.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            // Push and pop never touch the same slot: a full queue refuses the push.
            if (doPush) begin
                addr_q[tail_q]  <= inPort.inAddress;
                data_q[tail_q]  <= inPort.inData;
                valid_q[tail_q] <= 1'b1;
            end
            if (doPop) valid_q[head_q] <= 1'b0;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    logic [ADDR_WIDTH-1:0] ordAddr [DEPTH];
    logic [DATA_WIDTH-1:0] ordData [DEPTH];
    logic [DEPTH-1:0]      ordValid;

    // Rotate storage so index 0 is the head (oldest) for the match units.
    always_comb begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
            ordAddr[k]  = addr_q[head_q + PW'(k)];
            ordData[k]  = data_q[head_q + PW'(k)];
            ordValid[k] = valid_q[head_q + PW'(k)];
        end
    end

    reg_writeback_queue_wb_fwd_match #(
        .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)
    ) u_fwd0 (
        .readAddress_i(readAddress0), .entValid_i(ordValid),
        .entAddr_i(ordAddr), .entData_i(ordData),
        .fwdHit_o(fwdHit0), .fwdData_o(fwdData0)
    );

    reg_writeback_queue_wb_fwd_match #(
        .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)
    ) u_fwd1 (
        .readAddress_i(readAddress1), .entValid_i(ordValid),
        .entAddr_i(ordAddr), .entData_i(ordData),
        .fwdHit_o(fwdHit1), .fwdData_o(fwdData1)
    );

    a_count_bound: assert property (@(posedge clk) disable iff (!resetN) count_q <= FULL_COUNT)
        else $error("writeback queue occupancy out of range");

endmodule
